// File: rtl/clock_monitor_pkg.sv
// Shared types and helpers for the clock monitor.
// Holds the FSM encoding and the tolerance arithmetic.
package clock_monitor_pkg;

    localparam int unsigned DIFF_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_e;

    // Absolute difference via a one-bit-wider signed subtraction.
    function automatic logic [DIFF_W-1:0] abs_diff(
        input logic [DIFF_W-1:0] a,
        input logic [DIFF_W-1:0] b
    );
        logic signed [DIFF_W:0] d;
        logic        [DIFF_W:0] m;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        m = d[DIFF_W] ? -d : d;
        return m[DIFF_W-1:0];
    endfunction

endpackage

// File: rtl/clock_monitor_sync.sv
// Generic multi-flop synchronizer for asynchronous inputs.
// Every stage resets to INITIAL_VAL.
module clock_monitor_sync #(
    parameter int unsigned           WIDTH       = 1,
    parameter int unsigned           STAGES      = 2,
    parameter logic [WIDTH-1:0]      INITIAL_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= INITIAL_VAL;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clock_monitor.sv
// Measures period and high time of an asynchronous clock in clk cycles,
// flags out-of-tolerance periods and a stopped clock.
module clock_monitor
    import clock_monitor_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 1024,
    parameter int unsigned EXP_PERIOD  = 10,
    parameter int unsigned TOLERANCE   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             mon_in,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             in_range,
    output logic             range_err,
    output logic             stopped,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_V = CNT_W'(TIMEOUT);

    logic             ms;
    logic             ms_d_q;
    logic             rise_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             inr_q, inr_d;
    logic             err_q, err_d;
    logic             stop_q, stop_d;
    logic             stuck_q, stuck_d;
    logic             timeout;
    logic             in_range_now;

    clock_monitor_sync #(
        .WIDTH       (1),
        .STAGES      (SYNC_STAGES),
        .INITIAL_VAL (1'b0)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (mon_in),
        .q_o   (ms)
    );

    assign timeout      = (per_q == TO_V);
    assign in_range_now = abs_diff(DIFF_W'(per_q), DIFF_W'(EXP_PERIOD))
                          <= DIFF_W'(TOLERANCE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms_d_q   <= 1'b0;
            rise_q   <= 1'b0;
            state_q  <= IDLE;
            per_q    <= '0;
            hi_q     <= '0;
            valid_q  <= 1'b0;
            period_q <= '0;
            high_q   <= '0;
            inr_q    <= 1'b0;
            err_q    <= 1'b0;
            stop_q   <= 1'b0;
            stuck_q  <= 1'b0;
        end else begin
            ms_d_q   <= ms;
            rise_q   <= ms & ~ms_d_q;
            state_q  <= state_d;
            per_q    <= per_d;
            hi_q     <= hi_d;
            valid_q  <= valid_d;
            period_q <= period_d;
            high_q   <= high_d;
            inr_q    <= inr_d;
            err_q    <= err_d;
            stop_q   <= stop_d;
            stuck_q  <= stuck_d;
        end
    end

    // rise_q and ms_d_q describe the same synchronized sample.
    always_comb begin
        state_d  = state_q;
        per_d    = per_q;
        hi_d     = hi_q;
        valid_d  = 1'b0;
        period_d = period_q;
        high_d   = high_q;
        inr_d    = inr_q;
        err_d    = err_q & ~clear;
        stop_d   = stop_q;
        stuck_d  = stuck_q;
        unique case (state_q)
            IDLE: begin
                per_d  = '0;
                hi_d   = '0;
                stop_d = 1'b0;
                if (enable) state_d = ARM;
            end
            ARM: begin
                if (!enable) begin
                    state_d = IDLE;
                    stop_d  = 1'b0;
                end else if (rise_q) begin
                    per_d   = ONE;
                    hi_d    = ONE;
                    stop_d  = 1'b0;
                    state_d = MEASURE;
                end else if (!stop_q && timeout) begin
                    stop_d  = 1'b1;
                    stuck_d = ms_d_q;
                end else if (!timeout) begin
                    per_d = per_q + ONE;
                end
            end
            MEASURE: begin
                if (!enable) begin
                    state_d = IDLE;
                    stop_d  = 1'b0;
                end else if (rise_q) begin
                    valid_d  = 1'b1;
                    period_d = per_q;
                    high_d   = hi_q;
                    inr_d    = in_range_now;
                    if (!in_range_now) err_d = 1'b1;
                    per_d    = ONE;
                    hi_d     = ONE;
                end else if (timeout) begin
                    stop_d  = 1'b1;
                    stuck_d = ms_d_q;
                    state_d = ARM;
                end else begin
                    per_d = per_q + ONE;
                    if (ms_d_q) hi_d = hi_q + ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign meas_valid  = valid_q;
    assign meas_period = period_q;
    assign meas_high   = high_q;
    assign in_range    = inr_q;
    assign range_err   = err_q;
    assign stopped     = stop_q;
    assign stuck_level = stuck_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor with a sample-history reference model.
module tb_clock_monitor;

    localparam int CNT_W = 16;
    localparam int S     = 2;
    localparam int TO    = 64;
    localparam int EXP   = 10;
    localparam int TOL   = 1;

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic             clear;
    logic             mon_in;
    logic             meas_valid;
    logic [CNT_W-1:0] meas_period;
    logic [CNT_W-1:0] meas_high;
    logic             in_range;
    logic             range_err;
    logic             stopped;
    logic             stuck_level;

    clock_monitor #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (S),
        .TIMEOUT     (TO),
        .EXP_PERIOD  (EXP),
        .TOLERANCE   (TOL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .clear       (clear),
        .mon_in      (mon_in),
        .meas_valid  (meas_valid),
        .meas_period (meas_period),
        .meas_high   (meas_high),
        .in_range    (in_range),
        .range_err   (range_err),
        .stopped     (stopped),
        .stuck_level (stuck_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endtask

    // Model: each posedge sees the mon_in sample taken S+1 edges earlier.
    int ecount = 0;
    bit hist [8192];
    int vs = 0;
    bit m_active, m_have_ref, m_stop, m_stuck, m_valid, m_inr, m_err;
    int m_ref, m_base, m_period, m_high;

    int n_valid = 0, vedge = 0, n_stops = 0, stop_edge = 0;
    bit stp_prev = 0;

    function automatic bit smp(input int i);
        return (i >= vs && i >= 0) ? hist[i] : 1'b0;
    endfunction

    task automatic model_reset();
        m_active = 0; m_have_ref = 0; m_stop = 0; m_stuck = 0;
        m_valid = 0; m_inr = 0; m_err = 0;
        m_period = 0; m_high = 0; m_ref = 0; m_base = 0;
        vs = ecount + 1;
    endtask

    task automatic model_step();
        bit lv, pv, r;
        int d;
        hist[ecount] = mon_in;
        lv = smp(ecount - S - 1);
        pv = smp(ecount - S - 2);
        r  = lv & ~pv;
        m_valid = 0;
        if (!m_active) begin
            m_have_ref = 0;
            m_stop     = 0;
            m_base     = ecount + 1;
        end else if (!enable) begin
            m_have_ref = 0;
            m_stop     = 0;
        end else if (r) begin
            if (m_have_ref) begin
                m_valid  = 1;
                m_period = ecount - m_ref;
                m_high   = 0;
                for (int x = m_ref; x < ecount; x++) m_high += smp(x - S - 1);
                d = m_period - EXP;
                if (d < 0) d = -d;
                m_inr = (d <= TOL);
            end
            m_ref = ecount;
            m_have_ref = 1;
            m_stop = 0;
        end else if (!m_stop &&
                     (ecount - (m_have_ref ? m_ref : m_base)) == TO) begin
            m_stop     = 1;
            m_stuck    = lv;
            m_have_ref = 0;
        end
        if (m_valid && !m_inr) m_err = 1;
        else if (clear) m_err = 0;
        m_active = enable;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            ecount++;
            if (!rst_n) model_reset();
            else model_step();
            #1;
            chk($sformatf("valid@%0d", ecount), meas_valid, m_valid);
            chk($sformatf("stopped@%0d", ecount), stopped, m_stop);
            chk($sformatf("stuck@%0d", ecount), stuck_level, m_stuck);
            chk($sformatf("range_err@%0d", ecount), range_err, m_err);
            chk($sformatf("period@%0d", ecount), meas_period, m_period);
            chk($sformatf("high@%0d", ecount), meas_high, m_high);
            chk($sformatf("in_range@%0d", ecount), in_range, m_inr);
            if (meas_valid) begin
                n_valid++;
                vedge = ecount;
            end
            if (stopped && !stp_prev) begin
                n_stops++;
                stop_edge = ecount;
            end
            stp_prev = stopped;
        end
    end

    int last_rise = 0;

    task automatic wave(input int per, input int hi, input int n);
        for (int i = 0; i < n; i++) begin
            mon_in = 1'b1;
            last_rise = ecount + 1;
            repeat (hi) @(negedge clk);
            mon_in = 1'b0;
            repeat (per - hi) @(negedge clk);
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
    endtask

    int v0, s0;

    initial begin
        rst_n = 1'b0; enable = 1'b0; clear = 1'b0; mon_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", meas_valid, 0);
        chk("rst_period", meas_period, 0);
        chk("rst_high", meas_high, 0);
        chk("rst_stopped", stopped, 0);
        chk("rst_err", range_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);

        v0 = n_valid;
        wave(10, 5, 4);
        chk("t1_count", n_valid - v0, 3);
        chk("t1_period", meas_period, 10);
        chk("t1_high", meas_high, 5);
        chk("t1_in_range", in_range, 1);
        chk("t1_err", range_err, 0);
        chk("t1_latency", vedge - last_rise + 1, S + 2);

        v0 = n_valid;
        wave(8, 2, 3);
        chk("t2_count", n_valid - v0, 3);
        chk("t2_period8", meas_period, 8);
        chk("t2_high2", meas_high, 2);
        chk("t2_err8", range_err, 1);
        pulse_clear();
        chk("t2_clear8", range_err, 0);
        wave(13, 6, 2);
        chk("t2_period13", meas_period, 13);
        chk("t2_inr13", in_range, 0);
        chk("t2_err13", range_err, 1);
        pulse_clear();
        chk("t2_clear13", range_err, 0);
        chk("t2_inr_hold", in_range, 0);
        wave(11, 5, 2);
        chk("t2_period11", meas_period, 11);
        chk("t2_inr11", in_range, 1);
        wave(9, 4, 2);
        chk("t2_period9", meas_period, 9);
        chk("t2_high4", meas_high, 4);
        chk("t2_inr9", in_range, 1);
        pulse_clear();

        s0 = n_stops;
        v0 = n_valid;
        mon_in = 1'b1;
        last_rise = ecount + 1;
        repeat (75) @(negedge clk);
        chk("t3_stops", n_stops - s0, 1);
        chk("t3_stop_lat", stop_edge - last_rise, S + 1 + TO);
        chk("t3_stopped", stopped, 1);
        chk("t3_stuck", stuck_level, 1);
        chk("t3_valids", n_valid - v0, 1);
        mon_in = 1'b0;
        repeat (5) @(negedge clk);
        v0 = n_valid;
        wave(10, 5, 3);
        chk("t3_resume_stop", stopped, 0);
        chk("t3_resume_cnt", n_valid - v0, 2);
        chk("t3_resume_per", meas_period, 10);

        wave(10, 5, 1);
        s0 = n_stops;
        v0 = n_valid;
        wave(64, 32, 1);
        wave(65, 32, 1);
        wave(10, 5, 1);
        chk("t4_period64", meas_period, 64);
        chk("t4_high32", meas_high, 32);
        chk("t4_stops", n_stops - s0, 1);
        chk("t4_valids", n_valid - v0, 2);
        chk("t4_stopped", stopped, 0);

        wave(10, 5, 2);
        v0 = n_valid;
        mon_in = 1'b1;
        repeat (5) @(negedge clk);
        mon_in = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        wave(10, 5, 3);
        chk("t5_valids", n_valid - v0, 3);
        chk("t5_period", meas_period, 10);
        chk("t5_high", meas_high, 5);

        wave(10, 5, 1);
        mon_in = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid", meas_valid, 0);
        chk("t6_period", meas_period, 0);
        chk("t6_high", meas_high, 0);
        chk("t6_inr", in_range, 0);
        chk("t6_err", range_err, 0);
        chk("t6_stopped", stopped, 0);
        chk("t6_stuck", stuck_level, 0);
        mon_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        v0 = n_valid;
        wave(10, 5, 3);
        chk("t6_valids", n_valid - v0, 2);
        chk("t6_period2", meas_period, 10);
        chk("t6_high2", meas_high, 5);
        chk("t6_inr2", in_range, 1);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
